// File: rtl/hazard_stall_ctrl.sv
// ID-stage hazard controller: load-use and load-to-branch stalls, taken-branch squash,
// and a saturating count of inserted bubbles.
module hazard_stall_ctrl #(
  parameter int          REG_ADDR_WIDTH = 5,
  parameter int          CNT_WIDTH      = 16,
  parameter logic [6:0]  OP_LOAD        = 7'b0000011,
  parameter logic [6:0]  OP_BRANCH      = 7'b1100011
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      mem_stall,
  input  logic                      IF_ID_valid,
  input  logic [6:0]                IF_ID_inst_opcode,
  input  logic [REG_ADDR_WIDTH-1:0] IF_ID_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] IF_ID_rs2,
  input  logic                      ID_EX_mem_rd_en,
  input  logic [REG_ADDR_WIDTH-1:0] ID_EX_rd,
  input  logic                      EX_MEM_mem_rd_en,
  input  logic [REG_ADDR_WIDTH-1:0] EX_MEM_rd,
  input  logic                      branch_taken,
  input  logic                      stall_cnt_clr,
  output logic                      pc_wr_en,
  output logic                      IF_ID_wr_en,
  output logic                      IF_ID_flush,
  output logic                      ID_EX_flush,
  output logic [1:0]                hz_state,
  output logic [CNT_WIDTH-1:0]      stall_cnt
);

  typedef enum logic [1:0] {RUN = 2'b00, STALL1 = 2'b01, STALL2 = 2'b10} state_t;

  state_t               r_state;
  logic [CNT_WIDTH-1:0] r_cnt;

  logic w_run, w_branch, w_id_ex_hit, w_ex_mem_hit, w_h2, w_h1, w_bubble, w_taken;

  function automatic logic match(input logic [REG_ADDR_WIDTH-1:0] x,
                                 input logic [REG_ADDR_WIDTH-1:0] rd);
    return (rd != '0) && (rd == x);
  endfunction

  assign w_run        = (r_state == RUN);
  // A load opcode can never be treated as a branch, even if OP_BRANCH is mis-set to alias it.
  assign w_branch     = (IF_ID_inst_opcode == OP_BRANCH) && (IF_ID_inst_opcode != OP_LOAD);
  assign w_id_ex_hit  = ID_EX_mem_rd_en &&
                        (match(IF_ID_rs1, ID_EX_rd) || match(IF_ID_rs2, ID_EX_rd));
  assign w_ex_mem_hit = EX_MEM_mem_rd_en &&
                        (match(IF_ID_rs1, EX_MEM_rd) || match(IF_ID_rs2, EX_MEM_rd));

  assign w_h2 = w_run && IF_ID_valid && w_branch && w_id_ex_hit;
  assign w_h1 = w_run && IF_ID_valid && !w_h2 &&
                ((w_branch && w_ex_mem_hit) || (!w_branch && w_id_ex_hit));

  // mem_stall freezes everything, so it suppresses both the bubble and the squash.
  assign w_bubble = !mem_stall && (!w_run || w_h2 || w_h1);
  assign w_taken  = !mem_stall && w_run && IF_ID_valid && w_branch && branch_taken &&
                    !w_h2 && !w_h1;

  assign pc_wr_en    = !mem_stall && !w_bubble;
  assign IF_ID_wr_en = !mem_stall && !w_bubble;
  assign IF_ID_flush = w_taken;
  assign ID_EX_flush = w_bubble;
  assign hz_state    = r_state;
  assign stall_cnt   = r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RUN;
      r_cnt   <= '0;
    end else begin
      if (!mem_stall) begin
        case (r_state)
          RUN:     if (w_h2) r_state <= STALL2;
                   else if (w_h1) r_state <= STALL1;
          STALL2:  r_state <= STALL1;
          default: r_state <= RUN;
        endcase
      end
      // The counter only moves on real bubbles, which mem_stall already masks.
      if (stall_cnt_clr)
        r_cnt <= '0;
      else if (w_bubble && (r_cnt != '1))
        r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule
